// File: rtl/can_acf_bank_seq.sv
// CAN acceptance filter bank: NUM_FLT code/mask entries scanned sequentially,
// one entry per clock, lowest index wins.
module can_acf_bank_seq #(
    parameter int U_DLY   = 1,
    parameter int NUM_FLT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reset_mode,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_addr,
    input  logic        cfg_en,
    input  logic        cfg_ide,
    input  logic [28:0] cfg_code,
    input  logic [28:0] cfg_mask,
    output logic        cfg_ack,
    input  logic        start,
    input  logic        abort,
    input  logic [28:0] id,
    input  logic        ide,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic [3:0]  hit_idx
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [4:0] NUM_FLT_W = 5'(NUM_FLT);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_FLT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [28:0] id_reg;
    logic        ide_reg;
    logic        done_reg, done_next;
    logic        id_ok_reg, id_ok_next;
    logic [3:0]  hit_idx_reg, hit_idx_next;
    logic        cfg_ack_reg;
    logic [15:0] match;
    logic        wr_ok, start_ok, kill;

    assign busy     = (state_reg != IDLE);
    assign wr_ok    = cfg_wr && reset_mode && !busy && ({1'b0, cfg_addr} < NUM_FLT_W);
    assign start_ok = start && !abort && !reset_mode && (state_reg == IDLE);
    assign kill     = abort || reset_mode;

    // Match vector is padded to 16 so the 4-bit counter can index it directly.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_flt
            if (gi < NUM_FLT) begin : g_on
                logic        en_reg, ide_reg_k;
                logic [28:0] code_reg, mask_reg;
                logic [28:0] diff;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        en_reg    <= 1'b0;
                        ide_reg_k <= 1'b0;
                        code_reg  <= '0;
                        mask_reg  <= '0;
                    end else if (wr_ok && cfg_addr == 4'(gi)) begin
                        en_reg    <= cfg_en;
                        ide_reg_k <= cfg_ide;
                        code_reg  <= cfg_code;
                        mask_reg  <= cfg_mask;
                    end
                end

                assign diff = (id_reg ^ code_reg) & ~mask_reg;
                assign match[gi] = en_reg && (ide_reg_k == ide_reg) &&
                                   (ide_reg_k ? (diff == 29'd0) : (diff[10:0] == 11'd0));
            end else begin : g_off
                assign match[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        id_ok_next   = id_ok_reg;
        hit_idx_next = hit_idx_reg;
        if (kill) begin
            id_ok_next   = 1'b0;
            hit_idx_next = 4'd0;
        end
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next   = SCAN;
                    cnt_next     = 4'd0;
                    id_ok_next   = 1'b0;
                    hit_idx_next = 4'd0;
                end
            end
            SCAN: begin
                if (kill) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (match[cnt_reg]) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    id_ok_next   = 1'b1;
                    hit_idx_next = cnt_reg;
                end else if (cnt_reg == LAST_IDX) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    id_ok_next   = 1'b0;
                    hit_idx_next = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            id_reg      <= '0;
            ide_reg     <= 1'b0;
            done_reg    <= 1'b0;
            id_ok_reg   <= 1'b0;
            hit_idx_reg <= 4'd0;
            cfg_ack_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
            id_ok_reg   <= id_ok_next;
            hit_idx_reg <= hit_idx_next;
            cfg_ack_reg <= wr_ok;
            if (start_ok) begin
                id_reg  <= id;
                ide_reg <= ide;
            end
        end
    end

    assign done    = done_reg;
    assign id_ok   = id_ok_reg;
    assign hit_idx = hit_idx_reg;
    assign cfg_ack = cfg_ack_reg;

endmodule

// File: tb/tb_can_acf_bank_seq.sv
// Randomized bench for can_acf_bank_seq; expectations come from a first-match
// filter model over a shadow copy of the bank.
module tb_can_acf_bank_seq;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reset_mode = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_ide = 1'b0;
    logic [28:0] cfg_code = '0;
    logic [28:0] cfg_mask = '0;
    logic        cfg_ack;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [28:0] id = '0;
    logic        ide = 1'b0;
    logic        busy, done, id_ok;
    logic [3:0]  hit_idx;

    can_acf_bank_seq #(.U_DLY(1), .NUM_FLT(N)) dut (
        .clk(clk), .rst_n(rst_n), .reset_mode(reset_mode),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_ide(cfg_ide),
        .cfg_code(cfg_code), .cfg_mask(cfg_mask), .cfg_ack(cfg_ack),
        .start(start), .abort(abort), .id(id), .ide(ide),
        .busy(busy), .done(done), .id_ok(id_ok), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        m_en   [16];
    logic        m_ide  [16];
    logic [28:0] m_code [16];
    logic [28:0] m_mask [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 16; k++) begin
            m_en[k] = 1'b0; m_ide[k] = 1'b0; m_code[k] = '0; m_mask[k] = '0;
        end
    endtask

    // First enabled entry whose format matches and whose unmasked bits agree,
    // compared modulo 2^width of the frame format.
    function automatic int ref_hit(input logic [28:0] fid, input logic fide);
        longint span, d;
        for (int k = 0; k < N; k++) begin
            span = m_ide[k] ? (64'd1 << 29) : (64'd1 << 11);
            d = longint'(fid ^ m_code[k]) & ~longint'(m_mask[k]);
            if (m_en[k] && m_ide[k] == fide && (d % span) == 0) return k;
        end
        return -1;
    endfunction

    task automatic cfg_write(input int addr, input logic en_v, input logic ide_v,
                             input logic [28:0] code_v, input logic [28:0] mask_v);
        logic exp_ack;
        exp_ack = reset_mode && (addr < N);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = 4'(addr); cfg_en = en_v; cfg_ide = ide_v;
        cfg_code = code_v; cfg_mask = mask_v;
        @(negedge clk);
        cfg_wr = 1'b0;
        chk("cfg_ack", {31'd0, cfg_ack}, {31'd0, exp_ack});
        if (exp_ack) begin
            m_en[addr] = en_v; m_ide[addr] = ide_v; m_code[addr] = code_v; m_mask[addr] = mask_v;
        end
        $display("cfg  addr=%0d en=%0b ide=%0b code=%07h mask=%07h ack_exp=%0b ack=%0b",
                 addr, en_v, ide_v, code_v, mask_v, exp_ack, cfg_ack);
    endtask

    task automatic clear_bank();
        reset_mode = 1'b1;
        for (int k = 0; k < N; k++) cfg_write(k, 1'b0, 1'b0, 29'd0, 29'd0);
    endtask

    task automatic run_scan(input logic [28:0] sid, input logic side);
        int k, lat;
        k   = ref_hit(sid, side);
        lat = (k < 0) ? N + 1 : k + 2;
        @(negedge clk);
        start = 1'b1; id = sid; ide = side;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            chk("scan_busy", {31'd0, busy}, 32'd1);
            chk("scan_done", {31'd0, done}, (c == lat) ? 32'd1 : 32'd0);
        end
        chk("id_ok", {31'd0, id_ok}, (k >= 0) ? 32'd1 : 32'd0);
        chk("hit_idx", {28'd0, hit_idx}, (k >= 0) ? k : 0);
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("id_ok_hold", {31'd0, id_ok}, (k >= 0) ? 32'd1 : 32'd0);
        $display("scan id=%07h ide=%0b exp_hit=%0d id_ok=%0b hit_idx=%0d",
                 sid, side, k, id_ok, hit_idx);
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_id_ok", {31'd0, id_ok}, 32'd0);
        chk("rst_hit_idx", {28'd0, hit_idx}, 32'd0);
        chk("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_done", {31'd0, done}, 32'd0);
        chk("rel_cfg_ack", {31'd0, cfg_ack}, 32'd0);

        // Config gate
        reset_mode = 1'b0;
        cfg_write(0, 1'b1, 1'b0, 29'd0, 29'h1FFFFFFF);
        run_scan(29'd0, 1'b0);
        reset_mode = 1'b1;
        cfg_write(0, 1'b1, 1'b0, 29'd0, 29'h1FFFFFFF);
        cfg_write(N, 1'b1, 1'b0, 29'd0, 29'd0);

        // Standard hit at entry 2
        clear_bank();
        cfg_write(2, 1'b1, 1'b0, 29'h123, 29'd0);
        reset_mode = 1'b0;
        run_scan(29'h123, 1'b0);

        // Mask and priority
        clear_bank();
        cfg_write(1, 1'b1, 1'b1, 29'h1ABCDE00, 29'hFF);
        cfg_write(3, 1'b1, 1'b1, 29'd0, 29'h1FFFFFFF);
        reset_mode = 1'b0;
        run_scan(29'h1ABCDE5A, 1'b1);
        run_scan(29'h00000001, 1'b1);

        // Full miss
        reset_mode = 1'b1;
        for (int k = 0; k < N; k++) cfg_write(k, 1'b1, 1'b0, 29'(32'h100 + k), 29'd0);
        reset_mode = 1'b0;
        run_scan(29'h7FF, 1'b0);
        run_scan(29'h100 + 29'd5, 1'b1);

        // Abort in cycle T+3
        @(negedge clk);
        start = 1'b1; id = 29'h7FF; ide = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_id_ok", {31'd0, id_ok}, 32'd0);
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        $display("abort mid-scan busy=%0b id_ok=%0b", busy, id_ok);

        // Start coincident with abort, on an id that would hit entry 0
        @(negedge clk);
        start = 1'b1; abort = 1'b1; id = 29'h100; ide = 1'b0;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("sa_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("sa_busy2", {31'd0, busy}, 32'd0);
        chk("sa_id_ok", {31'd0, id_ok}, 32'd0);
        $display("start+abort busy=%0b id_ok=%0b", busy, id_ok);

        // Randomized configurations and scans
        for (int it = 0; it < 40; it++) begin
            logic [28:0] rid, rmask;
            logic        ride;
            int          e;
            reset_mode = 1'b1;
            for (int w = 0; w < 4; w++) begin
                case ($urandom_range(2))
                    0: rmask = 29'd0;
                    1: rmask = 29'($urandom);
                    default: rmask = 29'h1FFFFFFF;
                endcase
                cfg_write($urandom_range(N - 1), ($urandom_range(3) != 0),
                          1'($urandom_range(1)), 29'($urandom), rmask);
            end
            if ($urandom_range(1) == 1) begin
                e    = $urandom_range(N - 1);
                rid  = m_code[e] ^ (29'($urandom) & m_mask[e]);
                ride = m_ide[e];
                if (!ride) rid[28:11] = 18'($urandom);
            end else begin
                rid  = 29'($urandom);
                ride = 1'($urandom_range(1));
            end
            reset_mode = 1'b0;
            run_scan(rid, ride);
        end

        // Asynchronous reset mid-scan
        clear_bank();
        cfg_write(5, 1'b1, 1'b0, 29'h2AA, 29'd0);
        reset_mode = 1'b0;
        run_scan(29'h2AA, 1'b0);
        @(negedge clk);
        start = 1'b1; id = 29'h2AA; ide = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_id_ok", {31'd0, id_ok}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hit_idx", {28'd0, hit_idx}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_done", {31'd0, done}, 32'd0);
        chk("arst_rel_ack", {31'd0, cfg_ack}, 32'd0);
        $display("async reset mid-scan busy=%0b id_ok=%0b", busy, id_ok);
        run_scan(29'h2AA, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
